pwm_sample_sched: RTL and testbench
===================================

// Module: pwm_sample_sched
// PURPOSE
//  Sample scheduler/mixer for the DDR PWM audio output. On each PWM sample request it
//  polls up to NVOICES sample sources over a shared req/ack bus, sums their signed
//  samples with gain and saturation, and presents one offset-binary word to the PWM's
//  data input. It sits between the voice generators and the PWM output stage.
// PARAMETERS
//  NBITS      12    PWM word width; voice samples are signed NBITS
//  NVOICES    4     number of sources polled, 1..16
//  GAIN_SHIFT 2     arithmetic right shift applied to the accumulated sum
//  TIMEOUT    255   max cycles waited for voice_ack (used only with timeout feature)
// PORTS
//  sys_clk      in   1                  single clock for all logic
//  sys_rst_n    in   1                  asynchronous, active-low reset
//  next_val     in   1                  1-cycle strobe from PWM; PWM latches pwm_data this cycle
//  voice_en     in   NVOICES            per-voice enable mask, sampled at fetch start
//  voice_ack    in   1                  source accepts request; voice_data valid this cycle
//  voice_data   in   NBITS              signed sample from selected source
//  voice_req    out  1                  request, held until ack
//  voice_sel    out  max(1,clog2(NV))   index of polled source, stable while voice_req=1
//  pwm_data     out  NBITS              offset-binary word to PWM data_in
//  late         out  1                  1-cycle pulse: next_val arrived before mix finished
//  busy         out  1                  fetch in progress
//  timeout_err  out  1                  1-cycle pulse on voice timeout (0 if feature off)
// BEHAVIOUR
//  Reset: pwm_data=1<<(NBITS-1) (midscale), voice_req=0, voice_sel=0, late=0, busy=0,
//   timeout_err=0, FSM=IDLE, stage_valid=0, acc=0. Reset mid-handshake drops req at once.
//  FSM IDLE -> SCAN -> REQ -> (ACC) -> SCAN ... -> DONE -> IDLE.
//   IDLE: wait next_val. Cycle after next_val (t+1): if stage_valid, pwm_data<=stage and
//    stage_valid<=0; latch voice_en; acc<=0; k<=0; go SCAN.
//   SCAN: find the next enabled voice index >=k; none left -> DONE; else voice_sel<=index,
//    voice_req<=1, go REQ. Skipped voices cost one cycle each.
//   REQ: hold req/sel; on voice_ack: acc<=acc+sext(voice_data), voice_req<=0 next cycle,
//    k<=sel+1, go SCAN. Ack while voice_req=0 ignored. Min 2 cycles per enabled voice.
//   DONE: stage<=offset(sat(acc>>>GAIN_SHIFT)); stage_valid<=1; go IDLE.
//  Arithmetic: acc signed NBITS+clog2(NVOICES)+1 bits, never overflows. Shift arithmetic.
//   Saturate to [-2^(NBITS-1), 2^(NBITS-1)-1]; offset binary = invert MSB.
//  Latency: mix computed in period n is presented at period n+1's next_val (one sample).
//  busy=1 from leaving IDLE to entering IDLE.
//  next_val while busy: late pulses at t+1, pwm_data held (PWM repeats last word), fetch
//   continues uninterrupted; its result is presented at the following next_val.
//  next_val with stage_valid=0 and not busy (e.g. first after reset): pwm_data held, no late.
//  voice_en all zero: SCAN->DONE immediately, stage = midscale.
//  voice_en changes mid-fetch: ignored until next fetch start.
// CONFIGURATION
//  PWM_SCHED_TIMEOUT_EN defined: cycle counter in REQ; if TIMEOUT cycles pass without ack,
//   voice contributes 0, voice_req drops, timeout_err pulses 1 cycle, k advances.
//   Ack on the same cycle as expiry wins (sample accepted, no error).
//  Not defined: REQ waits indefinitely for ack; timeout_err tied 0; no counter logic.
// TESTING
//  T1 reset then NVOICES=4 all enabled, data 100,200,-50,0 ack 1 cycle after req, GAIN_SHIFT=2
//     -> after 2nd next_val pwm_data=0x800+62=0x83E; voice_sel walks 0..3.
//  T2 voice_en=4'b0101 -> only sel 0,2 requested; voice_en=0 -> pwm_data=0x800, no req.
//  T3 all voices +2047, GAIN_SHIFT=0 -> saturates to 0xFFF; all -2048 -> 0x000.
//  T4 ack delayed 1000 cycles with next_val every 50 -> late pulses, pwm_data held constant;
//     result appears on the next_val after fetch completes.
//  T5 (TIMEOUT_EN, TIMEOUT=8) voice 1 never acks -> timeout_err one pulse 8 cycles after
//     req, sum excludes voice 1; without macro bench sees req held, busy=1 indefinitely.
//  T6 assert sys_rst_n low while voice_req=1 -> req=0, pwm_data=0x800 immediately
//     (asynchronous); normal mixing resumes after release.

Source files
------------

// File: rtl/pwm_sample_sched.sv
// pwm_sample_sched: sample scheduler/mixer in front of the DDR PWM output stage.
// On each PWM sample request it polls the enabled voices over a shared req/ack
// bus, sums their signed samples, applies gain and saturation, and stages one
// offset-binary word that is presented at the following sample request.
// Optional feature: define PWM_SCHED_TIMEOUT_EN to abandon a voice that does
// not acknowledge within TIMEOUT cycles (it then contributes 0).
module pwm_sample_sched #(
    parameter int NBITS      = 12,
    parameter int NVOICES    = 4,
    parameter int GAIN_SHIFT = 2,
    parameter int TIMEOUT    = 255,
    localparam int SEL_W     = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               next_val,
    input  logic [NVOICES-1:0] voice_en,
    input  logic               voice_ack,
    input  logic [NBITS-1:0]   voice_data,
    output logic               voice_req,
    output logic [SEL_W-1:0]   voice_sel,
    output logic [NBITS-1:0]   pwm_data,
    output logic               late,
    output logic               busy,
    output logic               timeout_err
);

    // Accumulator is wide enough for NVOICES full-scale samples of either sign.
    localparam int ACC_W = NBITS + $clog2(NVOICES) + 1;
    // Scan index must be able to point one past the last voice.
    localparam int K_W   = SEL_W + 1;
    localparam logic [NBITS-1:0] MID = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic        [NBITS-1:0]   stage;
    logic                      stage_valid;
    logic        [NVOICES-1:0] en_lat;
    logic        [K_W-1:0]     k;
    logic                      any_left;
    logic                      hit;

`ifdef PWM_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;
`endif

    // Clamp the shifted sum into the signed NBITS range.
    function automatic logic signed [NBITS-1:0] sat(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] maxv;
        logic signed [ACC_W-1:0] minv;
        maxv = {{(ACC_W-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
        minv = {{(ACC_W-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
        if (v > maxv)
            sat = {1'b0, {(NBITS-1){1'b1}}};
        else if (v < minv)
            sat = {1'b1, {(NBITS-1){1'b0}}};
        else
            sat = v[NBITS-1:0];
    endfunction

    // Two's complement to offset binary: flip the sign bit.
    function automatic logic [NBITS-1:0] to_offset(input logic signed [NBITS-1:0] s);
        to_offset = {~s[NBITS-1], s[NBITS-2:0]};
    endfunction

    // Look ahead from the scan index: is any enabled voice left, and is the current one enabled.
    always_comb begin
        any_left = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < NVOICES; i++) begin
            if (en_lat[i] && (i >= int'(k)))
                any_left = 1'b1;
            if (i == int'(k))
                hit = en_lat[i];
        end
    end

    // Fetch/mix sequencer with registered bus and PWM-side outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            pwm_data    <= MID;
            voice_req   <= 1'b0;
            voice_sel   <= '0;
            late        <= 1'b0;
            busy        <= 1'b0;
            stage_valid <= 1'b0;
            stage       <= MID;
            acc         <= '0;
            k           <= '0;
            en_lat      <= '0;
`ifdef PWM_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
            tcnt        <= '0;
`endif
        end else begin
            // A sample request during a fetch means the PWM repeats its last word.
            late <= next_val && busy;
`ifdef PWM_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (next_val) begin
                        if (stage_valid) begin
                            pwm_data    <= stage;
                            stage_valid <= 1'b0;
                        end
                        en_lat <= voice_en;
                        acc    <= '0;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!any_left) begin
                        state <= DONE;
                    end else if (hit) begin
                        voice_sel <= k[SEL_W-1:0];
                        voice_req <= 1'b1;
                        state     <= REQ;
`ifdef PWM_SCHED_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                REQ: begin
                    if (voice_ack) begin
                        acc       <= acc + {{(ACC_W-NBITS){voice_data[NBITS-1]}}, voice_data};
                        voice_req <= 1'b0;
                        k         <= {1'b0, voice_sel} + K_W'(1);
                        state     <= SCAN;
                    end
`ifdef PWM_SCHED_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT - 1)) begin
                        voice_req   <= 1'b0;
                        timeout_err <= 1'b1;
                        k           <= {1'b0, voice_sel} + K_W'(1);
                        state       <= SCAN;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                DONE: begin
                    stage       <= to_offset(sat(acc >>> GAIN_SHIFT));
                    stage_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef PWM_SCHED_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Directed bench for pwm_sample_sched. Instance a uses GAIN_SHIFT=2, instance b
// uses GAIN_SHIFT=0 to reach saturation. Honors PWM_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_pwm_sample_sched;
    localparam int NB = 12;
    localparam int NV = 4;
`ifdef PWM_SCHED_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          next_val = 1'b0;
    logic [NV-1:0] voice_en = '0;
    logic          ack_a = 1'b0, ack_b = 1'b0;
    logic [NB-1:0] data_a = '0, data_b = '0;
    logic          req_a, req_b;
    logic [1:0]    sel_a, sel_b;
    logic [NB-1:0] pwm_a, pwm_b;
    logic          late_a, late_b, busy_a, busy_b, to_a, to_b;

    int asserts  = 0;
    int failures = 0;

    logic [NB-1:0] vdata [NV];
    int ack_delay  = 1;
    int dead_voice = -1;
    int wait_cnt   = 0;
    int sel_log[$];
    logic req_prev = 1'b0;

    pwm_sample_sched #(.NBITS(NB), .NVOICES(NV), .GAIN_SHIFT(2), .TIMEOUT(TO)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .next_val(next_val), .voice_en(voice_en),
        .voice_ack(ack_a), .voice_data(data_a), .voice_req(req_a), .voice_sel(sel_a),
        .pwm_data(pwm_a), .late(late_a), .busy(busy_a), .timeout_err(to_a));

    pwm_sample_sched #(.NBITS(NB), .NVOICES(NV), .GAIN_SHIFT(0), .TIMEOUT(TO)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .next_val(next_val), .voice_en(voice_en),
        .voice_ack(ack_b), .voice_data(data_b), .voice_req(req_b), .voice_sel(sel_b),
        .pwm_data(pwm_b), .late(late_b), .busy(busy_b), .timeout_err(to_b));

    // Voice source model for instance a: logs each request, acks after ack_delay cycles.
    always @(negedge clk) begin
        if (req_a && !req_prev)
            sel_log.push_back(int'(sel_a));
        req_prev = req_a;
        if (req_a && !ack_a) begin
            if (wait_cnt >= ack_delay && int'(sel_a) != dead_voice) begin
                ack_a  = 1'b1;
                data_a = vdata[sel_a];
            end else begin
                wait_cnt++;
            end
        end else begin
            ack_a    = 1'b0;
            wait_cnt = 0;
        end
    end

    // Voice source model for instance b: acks one cycle after each request.
    always @(negedge clk) begin
        if (req_b && !ack_b) begin
            ack_b  = 1'b1;
            data_b = vdata[sel_b];
        end else begin
            ack_b = 1'b0;
        end
    end

    task automatic set_data(input int d0, input int d1, input int d2, input int d3);
        vdata[0] = NB'(d0);
        vdata[1] = NB'(d1);
        vdata[2] = NB'(d2);
        vdata[3] = NB'(d3);
    endtask

    task automatic pulse_next();
        @(negedge clk);
        next_val = 1'b1;
        @(negedge clk);
        next_val = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy_a || busy_b) && n < budget) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (busy_a || busy_b) begin
            failures++;
            $display("FAIL wait_idle: busy_a=%0b busy_b=%0b after %0d cycles, required 0", busy_a, busy_b, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        asserts++;
        if (pwm_a !== 12'h800) begin
            failures++; $display("FAIL reset_pwm: got %h required 800", pwm_a);
        end
        asserts++;
        if ({req_a, sel_a, late_a, busy_a, to_a} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl: got req=%b sel=%0d late=%b busy=%b to=%b required all 0", req_a, sel_a, late_a, busy_a, to_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mix_basic();
        set_data(100, 200, -50, 0);
        voice_en = 4'hF;
        ack_delay = 1;
        sel_log.delete();
        pulse_next();
        asserts++;
        if ({late_a, pwm_a} !== {1'b0, 12'h800}) begin
            failures++; $display("FAIL t1_first: got late=%b pwm=%h required late=0 pwm=800", late_a, pwm_a);
        end
        wait_idle(200);
        asserts++;
        if (sel_log.size() != 4 || sel_log[0] != 0 || sel_log[1] != 1 || sel_log[2] != 2 || sel_log[3] != 3) begin
            failures++; $display("FAIL t1_sel_walk: got %p required 0,1,2,3", sel_log);
        end
        pulse_next();
        asserts++;
        if (pwm_a !== 12'h83E) begin
            failures++; $display("FAIL t1_mix_a: got %h required 83e", pwm_a);
        end
        asserts++;
        if (pwm_b !== 12'h8FA) begin
            failures++; $display("FAIL t1_mix_b: got %h required 8fa", pwm_b);
        end
        wait_idle(200);
    endtask

    task automatic test_enable_mask();
        voice_en = 4'b0101;
        sel_log.delete();
        pulse_next();
        wait_idle(200);
        asserts++;
        if (sel_log.size() != 2 || sel_log[0] != 0 || sel_log[1] != 2) begin
            failures++; $display("FAIL t2_mask_sel: got %p required 0,2", sel_log);
        end
        pulse_next();
        asserts++;
        if ({pwm_a, pwm_b} !== {12'h80C, 12'h832}) begin
            failures++; $display("FAIL t2_mask_mix: got a=%h b=%h required a=80c b=832", pwm_a, pwm_b);
        end
        wait_idle(200);
        voice_en = 4'b0000;
        sel_log.delete();
        pulse_next();
        wait_idle(200);
        asserts++;
        if (sel_log.size() != 0) begin
            failures++; $display("FAIL t2_none_req: got %0d requests required 0", sel_log.size());
        end
        pulse_next();
        asserts++;
        if ({pwm_a, pwm_b} !== {12'h800, 12'h800}) begin
            failures++; $display("FAIL t2_none_mix: got a=%h b=%h required 800", pwm_a, pwm_b);
        end
        wait_idle(200);
        voice_en = 4'hF;
        sel_log.delete();
        pulse_next();
        voice_en = 4'h0;
        wait_idle(200);
        asserts++;
        if (sel_log.size() != 4) begin
            failures++; $display("FAIL t2_en_midfetch: got %0d requests required 4", sel_log.size());
        end
        pulse_next();
        asserts++;
        if (pwm_a !== 12'h83E) begin
            failures++; $display("FAIL t2_en_midfetch_mix: got %h required 83e", pwm_a);
        end
        wait_idle(200);
        voice_en = 4'hF;
    endtask

    task automatic test_saturation();
        voice_en = 4'hF;
        set_data(2047, 2047, 2047, 2047);
        pulse_next();
        wait_idle(200);
        pulse_next();
        asserts++;
        if ({pwm_a, pwm_b} !== {12'hFFF, 12'hFFF}) begin
            failures++; $display("FAIL t3_pos_sat: got a=%h b=%h required fff", pwm_a, pwm_b);
        end
        wait_idle(200);
        set_data(-2048, -2048, -2048, -2048);
        pulse_next();
        wait_idle(200);
        pulse_next();
        asserts++;
        if ({pwm_a, pwm_b} !== {12'h000, 12'h000}) begin
            failures++; $display("FAIL t3_neg_sat: got a=%h b=%h required 000", pwm_a, pwm_b);
        end
        wait_idle(200);
    endtask

    task automatic test_late();
        set_data(100, 200, -50, 0);
        ack_delay = 1;
        pulse_next();
        wait_idle(200);
        set_data(400, 400, 400, 400);
        ack_delay = 1000;
        pulse_next();
        asserts++;
        if ({late_a, pwm_a} !== {1'b0, 12'h83E}) begin
            failures++; $display("FAIL t4_start: got late=%b pwm=%h required late=0 pwm=83e", late_a, pwm_a);
        end
        for (int i = 0; i < 10; i++) begin
            repeat (48) @(negedge clk);
            pulse_next();
            asserts++;
            if ({late_a, busy_a, pwm_a} !== {1'b1, 1'b1, 12'h83E}) begin
                failures++; $display("FAIL t4_late_%0d: got late=%b busy=%b pwm=%h required late=1 busy=1 pwm=83e", i, late_a, busy_a, pwm_a);
            end
        end
        @(negedge clk);
        asserts++;
        if (late_a !== 1'b0) begin
            failures++; $display("FAIL t4_late_width: got %b required 0", late_a);
        end
        wait_idle(6000);
        ack_delay = 1;
        pulse_next();
        asserts++;
        if ({late_a, pwm_a} !== {1'b0, 12'h990}) begin
            failures++; $display("FAIL t4_result: got late=%b pwm=%h required late=0 pwm=990", late_a, pwm_a);
        end
        wait_idle(200);
    endtask

    task automatic test_timeout();
        int n = 0;
        set_data(100, 200, -50, 0);
        ack_delay = 1;
        dead_voice = 1;
        voice_en = 4'hF;
        sel_log.delete();
        pulse_next();
        while (!(req_a && sel_a == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (!(req_a && sel_a == 2'd1)) begin
            failures++; $display("FAIL t5_req1: got req=%b sel=%0d required req=1 sel=1", req_a, sel_a);
        end
`ifdef PWM_SCHED_TIMEOUT_EN
        n = 0;
        while (!to_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (!to_a || n != 8) begin
            failures++; $display("FAIL t5_to_timing: got err=%b after %0d cycles required err=1 after 8", to_a, n);
        end
        @(negedge clk);
        asserts++;
        if (to_a !== 1'b0) begin
            failures++; $display("FAIL t5_to_width: got %b required 0", to_a);
        end
        wait_idle(200);
        asserts++;
        if (sel_log.size() != 4 || sel_log[3] != 3) begin
            failures++; $display("FAIL t5_continue: got %p required 0,1,2,3", sel_log);
        end
        dead_voice = -1;
        pulse_next();
        asserts++;
        if (pwm_a !== 12'h80C) begin
            failures++; $display("FAIL t5_mix: got %h required 80c", pwm_a);
        end
        wait_idle(200);
`else
        repeat (300) @(negedge clk);
        asserts++;
        if ({req_a, sel_a, busy_a, to_a} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL t5_hold: got req=%b sel=%0d busy=%b err=%b required req=1 sel=1 busy=1 err=0", req_a, sel_a, busy_a, to_a);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dead_voice = -1;
        @(negedge clk);
`endif
    endtask

    task automatic test_async_reset();
        int n = 0;
        set_data(100, 200, -50, 0);
        ack_delay = 1000;
        voice_en = 4'hF;
        pulse_next();
        while (!req_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        asserts++;
        if (req_a !== 1'b1) begin
            failures++; $display("FAIL t6_req_up: got %b required 1", req_a);
        end
        rst_n = 1'b0;
        #1;
        asserts++;
        if ({req_a, busy_a, pwm_a} !== {1'b0, 1'b0, 12'h800}) begin
            failures++; $display("FAIL t6_async: got req=%b busy=%b pwm=%h required req=0 busy=0 pwm=800", req_a, busy_a, pwm_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 1;
        @(negedge clk);
        pulse_next();
        asserts++;
        if ({late_a, pwm_a} !== {1'b0, 12'h800}) begin
            failures++; $display("FAIL t6_first: got late=%b pwm=%h required late=0 pwm=800", late_a, pwm_a);
        end
        wait_idle(200);
        pulse_next();
        asserts++;
        if (pwm_a !== 12'h83E) begin
            failures++; $display("FAIL t6_resume: got %h required 83e", pwm_a);
        end
        wait_idle(200);
    endtask

    initial begin
        set_data(0, 0, 0, 0);
        test_reset();
        test_mix_basic();
        test_enable_mask();
        test_saturation();
        test_late();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
